// File: rtl/fnd_pkg.sv
// fnd_pkg: 7-segment patterns (active-high gfedcba) and pin polarity helper shared by the FND driver.
package fnd_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h27;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
    return active_low ? ~pattern : pattern;
  endfunction
endpackage

// File: rtl/fnd_seg_lut.sv
// fnd_seg_lut: nibble to active-high gfedcba pattern; A-F go dark unless hex_mode.
module fnd_seg_lut
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);
  logic [6:0] pat;
  always_comb begin
    pat = SEG_OFF;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    seg = (nibble > 4'h9 && !hex_mode) ? SEG_OFF : pat;
  end
endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: multiplexed multi-digit 7-seg scanner with frame-aligned shadow update and anti-ghost blanking.
// Optional FND_LEADING_ZERO_SUPPRESS_EN darkens leading zero digits (digit 0 always shown).
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW = $clog2(DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [6:0] SEG_DARK = seg_polarity(SEG_OFF, AL);
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] stg_val_q, stg_val_d, shd_val_q, shd_val_d;
  logic stg_hex_q, stg_hex_d, shd_hex_q, shd_hex_d, pending_q, pending_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d, lz;
  logic [6:0] seg_q, seg_d, lut_seg;
  logic dp_q, dp_d, fd_q, fd_d;
  logic wrap, last, boundary, blanking, dark;
  logic [3:0] nib;
  fnd_seg_lut u_lut (.nibble(nib), .hex_mode(shd_hex_q), .seg(lut_seg));
`ifdef FND_LEADING_ZERO_SUPPRESS_EN
  logic zrun;
  always_comb begin
    lz = '0;
    zrun = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun = zrun & (shd_val_q[i*4 +: 4] == 4'h0);
      lz[i] = zrun;
    end
  end
`else
  assign lz = '0;
`endif
  always_comb begin
    wrap = pre_q == PW'(DIV - 1);
    last = idx_q == IW'(NUM_DIGITS - 1);
    boundary = wrap && last;
    pre_d = wrap ? '0 : pre_q + PW'(1);
    idx_d = wrap ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    stg_val_d = load ? value : stg_val_q;
    stg_hex_d = load ? hex_mode : stg_hex_q;
    stg_blank_d = load ? blank_mask : stg_blank_q;
    stg_dp_d = load ? dp_mask : stg_dp_q;
    pending_d = !boundary && (load || pending_q);
    // a load landing on the boundary bypasses staging so it shows in the very next frame
    shd_val_d = !boundary ? shd_val_q : load ? value : pending_q ? stg_val_q : shd_val_q;
    shd_hex_d = !boundary ? shd_hex_q : load ? hex_mode : pending_q ? stg_hex_q : shd_hex_q;
    shd_blank_d = !boundary ? shd_blank_q : load ? blank_mask : pending_q ? stg_blank_q : shd_blank_q;
    shd_dp_d = !boundary ? shd_dp_q : load ? dp_mask : pending_q ? stg_dp_q : shd_dp_q;
    nib = shd_val_q[idx_q*4 +: 4];
    dark = shd_blank_q[idx_q] | lz[idx_q];
    blanking = pre_q < PW'(BLANK_CYCLES);
    en_d = blanking ? '0 : NUM_DIGITS'(1) << idx_q;
    seg_d = seg_polarity((blanking || dark) ? SEG_OFF : lut_seg, AL);
    dp_d = AL ^ (!blanking && shd_dp_q[idx_q]);
    fd_d = boundary;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      stg_val_q <= '0;
      stg_hex_q <= 1'b0;
      stg_blank_q <= '0;
      stg_dp_q <= '0;
      shd_val_q <= '0;
      shd_hex_q <= 1'b0;
      shd_blank_q <= '0;
      shd_dp_q <= '0;
      pending_q <= 1'b0;
      en_q <= '0;
      seg_q <= SEG_DARK;
      dp_q <= AL;
      fd_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      stg_val_q <= stg_val_d;
      stg_hex_q <= stg_hex_d;
      stg_blank_q <= stg_blank_d;
      stg_dp_q <= stg_dp_d;
      shd_val_q <= shd_val_d;
      shd_hex_q <= shd_hex_d;
      shd_blank_q <= shd_blank_d;
      shd_dp_q <= shd_dp_d;
      pending_q <= pending_d;
      en_q <= en_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  end
  assign seg_out = seg_q;
  assign dp_out = dp_q;
  assign digit_en = en_q;
  assign frame_done = fd_q;
endmodule
